mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max bus_req_o cycles without bus_ack_i before abort (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_op_valid  input  1  MEM stage presents an operation this cycle.
REQ-005 mem_op  input  8  decode_table::alu_op_t; memory ops are LW_OP(10), LB_OP(11), SB_OP(12), SW_OP(13); all other codes are non-memory.
REQ-006 mem_addr  input  32  byte address of the access.
REQ-007 mem_wdata  input  32  store data (SB uses bits 7:0).
REQ-008 stall_o  output  1  holds the pipeline while an access is pending.
REQ-009 ld_valid_o  output  1  one-cycle pulse: access finished (load data or store complete).
REQ-010 ld_data_o  output  32  load result, valid while ld_valid_o is high.
REQ-011 err_o  output  1  one-cycle pulse with ld_valid_o: misaligned or timed-out access.
REQ-012 bus_req_o  output  1  data-bus request.
REQ-013 bus_we_o  output  1  1 = write, 0 = read.
REQ-014 bus_addr_o  output  32  word-aligned bus address ({addr[31:2],2'b00}).
REQ-015 bus_wdata_o  output  32  write data.
REQ-016 bus_be_o  output  4  byte enables, bit i = byte lane i (little-endian).
REQ-017 bus_ack_i  input  1  bus completes the request this cycle; bus_rdata_i valid in the same cycle.
REQ-018 bus_rdata_i  input  32  read data.

Function
REQ-019 FSM states IDLE, BUSY, RESP; all outputs registered except stall_o.
REQ-020 IDLE: mem_op_valid with a memory op captures op/addr/wdata; next state BUSY, or RESP with error if misaligned.
REQ-021 IDLE: mem_op_valid with a non-memory op, or mem_op_valid low: no capture, stay IDLE, stall_o low.
REQ-022 Misaligned = LW/SW with addr[1:0] != 0; no bus access; RESP with err_o=1, ld_data_o=0.
REQ-023 stall_o = (IDLE and mem_op_valid and memory op) or BUSY; low in RESP.
REQ-024 BUSY: bus_req_o=1; bus_we_o/addr/wdata/be held constant for the whole of BUSY.
REQ-025 LW/SW: bus_be_o=4'b1111, bus_wdata_o=wdata; SB: bus_be_o=1<<addr[1:0], bus_wdata_o=wdata[7:0] replicated to all 4 lanes; LB: bus_be_o=1<<addr[1:0].
REQ-026 BUSY with bus_ack_i=1: bus_req_o drops next cycle; state RESP; loads register the result.
REQ-027 LW result = bus_rdata_i; LB result = sign-extended byte lane addr[1:0] of bus_rdata_i; store ld_data_o=0.
REQ-028 8-bit wait counter cleared on BUSY entry, incremented each BUSY cycle without ack; when it reaches TIMEOUT without ack: RESP with err_o=1, ld_data_o=0.
REQ-029 Ack in the same cycle the counter reaches TIMEOUT counts as success.
REQ-030 RESP lasts exactly one cycle: ld_valid_o=1, err_o per REQ-022/028; next state IDLE; mem_op_valid is not sampled in RESP.
REQ-031 Minimum latency: capture cycle 0, bus_req_o high cycle 1, ack cycle 1, ld_valid_o cycle 2.
REQ-032 bus_ack_i outside BUSY is ignored.

Reset
REQ-033 rst_n low asynchronously forces IDLE, clears the counter and captured fields, and drives every output to 0 (stall_o=0, bus_req_o=0, bus_be_o=0, ld_valid_o=0, err_o=0).
REQ-034 Reset during BUSY abandons the access; no ld_valid_o pulse follows reset release.

Verification
REQ-035 LW addr 0x100, ack in cycle 1 with rdata 0xDEADBEEF -> bus_be_o=4'hF, ld_valid_o at cycle 2, ld_data_o=0xDEADBEEF, stall_o high cycles 0-1.
REQ-036 LB addr 0x103, rdata 0x80FF0000 after 3 wait cycles -> bus_addr_o=0x100, bus_be_o=4'b1000, ld_data_o=0xFFFFFF80, request fields stable throughout.
REQ-037 SB addr 0x202, wdata 0x000000A5 -> bus_we_o=1, bus_be_o=4'b0100, bus_wdata_o=0xA5A5A5A5, ld_valid_o pulse, ld_data_o=0.
REQ-038 SW addr 0x101 -> no bus_req_o, RESP next cycle with err_o=1, ld_valid_o=1.
REQ-039 LW with TIMEOUT=15 and no ack -> bus_req_o high exactly 15 cycles, then err_o=1, ld_data_o=0; a second run with ack on the 15th cycle -> success.
REQ-040 rst_n low mid-BUSY -> bus_req_o and stall_o drop immediately; after release stays IDLE, no ld_valid_o; ADD_OP with mem_op_valid -> stall_o stays 0.

Source files
------------

// File: rtl/mem_access_if.sv
// Bundles the MEM-stage request, pipeline response and data-bus signals of the
// memory access controller. The controller takes the slave modport.
interface mem_access_if;
  logic        mem_op_valid;
  logic [7:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall_o;
  logic        ld_valid_o;
  logic [31:0] ld_data_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport slave (
    input  mem_op_valid, mem_op, mem_addr, mem_wdata, bus_ack_i, bus_rdata_i,
    output stall_o, ld_valid_o, ld_data_o, err_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
  );

  modport master (
    output mem_op_valid, mem_op, mem_addr, mem_wdata, bus_ack_i, bus_rdata_i,
    input  stall_o, ld_valid_o, ld_data_o, err_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: captures one memory op, runs it on the data bus
// with a wait timeout, and returns a one-cycle completion pulse to the pipeline.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_if.slave ctrl_if
);

  localparam logic [7:0] LwOp = 8'd10;
  localparam logic [7:0] LbOp = 8'd11;
  localparam logic [7:0] SbOp = 8'd12;
  localparam logic [7:0] SwOp = 8'd13;
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  op_q;
  logic [1:0]  lane_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic        ld_valid_q;
  logic [31:0] ld_data_q;
  logic        err_q;

  logic        is_mem;
  logic        is_word;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic [7:0]  rd_byte;
  logic [31:0] load_data;
  logic [7:0]  cnt_inc;

  always_comb begin
    is_mem     = (ctrl_if.mem_op == LwOp) || (ctrl_if.mem_op == LbOp) ||
                 (ctrl_if.mem_op == SbOp) || (ctrl_if.mem_op == SwOp);
    is_word    = (ctrl_if.mem_op == LwOp) || (ctrl_if.mem_op == SwOp);
    is_store   = (ctrl_if.mem_op == SbOp) || (ctrl_if.mem_op == SwOp);
    misaligned = is_word && (ctrl_if.mem_addr[1:0] != 2'b00);
    cap_be     = is_word ? 4'b1111 : (4'b0001 << ctrl_if.mem_addr[1:0]);
    if (ctrl_if.mem_op == SbOp) begin
      cap_wdata = {4{ctrl_if.mem_wdata[7:0]}};
    end else if (ctrl_if.mem_op == LbOp) begin
      cap_wdata = '0;
    end else begin
      cap_wdata = ctrl_if.mem_wdata;
    end
  end

  always_comb begin
    unique case (lane_q)
      2'd0:    rd_byte = ctrl_if.bus_rdata_i[7:0];
      2'd1:    rd_byte = ctrl_if.bus_rdata_i[15:8];
      2'd2:    rd_byte = ctrl_if.bus_rdata_i[23:16];
      default: rd_byte = ctrl_if.bus_rdata_i[31:24];
    endcase
    if (op_q == LwOp) begin
      load_data = ctrl_if.bus_rdata_i;
    end else if (op_q == LbOp) begin
      load_data = {{24{rd_byte[7]}}, rd_byte};
    end else begin
      load_data = '0;
    end
    cnt_inc = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      lane_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      ld_valid_q <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ctrl_if.mem_op_valid && is_mem) begin
            op_q   <= ctrl_if.mem_op;
            lane_q <= ctrl_if.mem_addr[1:0];
            cnt_q  <= '0;
            if (misaligned) begin
              // Misaligned word access never reaches the bus.
              state_q    <= StResp;
              ld_valid_q <= 1'b1;
              err_q      <= 1'b1;
              ld_data_q  <= '0;
            end else begin
              state_q     <= StBusy;
              bus_req_q   <= 1'b1;
              bus_we_q    <= is_store;
              bus_addr_q  <= {ctrl_if.mem_addr[31:2], 2'b00};
              bus_wdata_q <= cap_wdata;
              bus_be_q    <= cap_be;
            end
          end
        end
        StBusy: begin
          // Ack is checked before the timeout so a last-cycle ack still succeeds.
          if (ctrl_if.bus_ack_i || (cnt_inc == TimeoutCnt)) begin
            state_q     <= StResp;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            ld_valid_q  <= 1'b1;
            err_q       <= !ctrl_if.bus_ack_i;
            ld_data_q   <= ctrl_if.bus_ack_i ? load_data : '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          ld_data_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ctrl_if.stall_o = rst_n && (((state_q == StIdle) && ctrl_if.mem_op_valid && is_mem) ||
                                     (state_q == StBusy));
  assign ctrl_if.ld_valid_o  = ld_valid_q;
  assign ctrl_if.ld_data_o   = ld_data_q;
  assign ctrl_if.err_o       = err_q;
  assign ctrl_if.bus_req_o   = bus_req_q;
  assign ctrl_if.bus_we_o    = bus_we_q;
  assign ctrl_if.bus_addr_o  = bus_addr_q;
  assign ctrl_if.bus_wdata_o = bus_wdata_q;
  assign ctrl_if.bus_be_o    = bus_be_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: expected completions are queued per access and
// compared by a monitor whenever ld_valid_o is seen.
module tb_mem_access_ctrl;

  localparam logic [7:0] LwOp  = 8'd10;
  localparam logic [7:0] LbOp  = 8'd11;
  localparam logic [7:0] SbOp  = 8'd12;
  localparam logic [7:0] SwOp  = 8'd13;
  localparam logic [7:0] AddOp = 8'd1;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic  clk;
  logic  rst_n;
  int    n_checks = 0;
  int    n_fail   = 0;
  resp_t exp_q[$];

  mem_access_if u_if ();

  mem_access_ctrl #(.TIMEOUT(15)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic err, input logic [31:0] data);
    resp_t r;
    r.name = name;
    r.err  = err;
    r.data = data;
    exp_q.push_back(r);
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && u_if.ld_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: ld_valid_o=1 err_o=%0b data=0x%08h, expected no pulse",
                 u_if.err_o, u_if.ld_data_o);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_err"}, {31'b0, u_if.err_o}, {31'b0, e.err});
        check({e.name, "_data"}, u_if.ld_data_o, e.data);
      end
    end
  end

  // Entered at posedge+1 in IDLE; leaves at posedge+1 of cycle 1.
  task automatic start_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata);
    u_if.mem_op_valid = 1'b1;
    u_if.mem_op       = op;
    u_if.mem_addr     = addr;
    u_if.mem_wdata    = wdata;
    @(negedge clk);
    check({name, "_stall_c0"}, {31'b0, u_if.stall_o}, 32'd1);
    check({name, "_req_c0"}, {31'b0, u_if.bus_req_o}, 32'd0);
    @(posedge clk);
    #1;
    u_if.mem_op_valid = 1'b0;
  endtask

  task automatic busy_phase(input string name, input int nwait, input bit ack_en,
                            input logic [31:0] rdata, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
    for (int i = 0; i <= nwait; i++) begin
      u_if.bus_rdata_i = rdata;
      u_if.bus_ack_i   = ack_en && (i == nwait);
      @(negedge clk);
      check($sformatf("%s_req_b%0d", name, i), {31'b0, u_if.bus_req_o}, 32'd1);
      check($sformatf("%s_stall_b%0d", name, i), {31'b0, u_if.stall_o}, 32'd1);
      check($sformatf("%s_we_b%0d", name, i), {31'b0, u_if.bus_we_o}, {31'b0, we});
      check($sformatf("%s_addr_b%0d", name, i), u_if.bus_addr_o, addr);
      check($sformatf("%s_wdata_b%0d", name, i), u_if.bus_wdata_o, wdata);
      check($sformatf("%s_be_b%0d", name, i), {28'b0, u_if.bus_be_o}, {28'b0, be});
      @(posedge clk);
      #1;
      u_if.bus_ack_i = 1'b0;
    end
  endtask

  task automatic resp_phase(input string name);
    @(negedge clk);
    check({name, "_ld_valid"}, {31'b0, u_if.ld_valid_o}, 32'd1);
    check({name, "_req_resp"}, {31'b0, u_if.bus_req_o}, 32'd0);
    check({name, "_stall_resp"}, {31'b0, u_if.stall_o}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n             = 1'b1;
    u_if.mem_op_valid = 1'b0;
    u_if.mem_op       = '0;
    u_if.mem_addr     = '0;
    u_if.mem_wdata    = '0;
    u_if.bus_ack_i    = 1'b0;
    u_if.bus_rdata_i  = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_stall", {31'b0, u_if.stall_o}, 32'd0);
    check("rst_req", {31'b0, u_if.bus_req_o}, 32'd0);
    check("rst_be", {28'b0, u_if.bus_be_o}, 32'd0);
    check("rst_ld_valid", {31'b0, u_if.ld_valid_o}, 32'd0);
    check("rst_err", {31'b0, u_if.err_o}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LW, minimum latency
    push_exp("lw100", 1'b0, 32'hDEADBEEF);
    start_op("lw100", LwOp, 32'h0000_0100, 32'h0);
    busy_phase("lw100", 0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h100, 32'h0, 4'hF);
    resp_phase("lw100");

    // LB lane 3 with three wait cycles, negative byte
    push_exp("lb103", 1'b0, 32'hFFFF_FF80);
    start_op("lb103", LbOp, 32'h0000_0103, 32'h0);
    busy_phase("lb103", 3, 1'b1, 32'h80FF_0000, 1'b0, 32'h100, 32'h0, 4'b1000);
    resp_phase("lb103");

    // LB lane 1, positive byte
    push_exp("lb101", 1'b0, 32'h0000_007F);
    start_op("lb101", LbOp, 32'h0000_0101, 32'h0);
    busy_phase("lb101", 1, 1'b1, 32'h0000_7F00, 1'b0, 32'h100, 32'h0, 4'b0010);
    resp_phase("lb101");

    // SB lane 2
    push_exp("sb202", 1'b0, 32'h0);
    start_op("sb202", SbOp, 32'h0000_0202, 32'h0000_00A5);
    busy_phase("sb202", 1, 1'b1, 32'h1234_5678, 1'b1, 32'h200, 32'hA5A5_A5A5, 4'b0100);
    resp_phase("sb202");

    // SW aligned
    push_exp("sw208", 1'b0, 32'h0);
    start_op("sw208", SwOp, 32'h0000_0208, 32'h1122_3344);
    busy_phase("sw208", 0, 1'b1, 32'h5555_AAAA, 1'b1, 32'h208, 32'h1122_3344, 4'hF);
    resp_phase("sw208");

    // SW misaligned: straight to the error response
    push_exp("sw101", 1'b1, 32'h0);
    start_op("sw101", SwOp, 32'h0000_0101, 32'hFFFF_FFFF);
    resp_phase("sw101");

    // LW timeout: exactly 15 request cycles
    push_exp("lw_to", 1'b1, 32'h0);
    start_op("lw_to", LwOp, 32'h0000_0400, 32'h0);
    busy_phase("lw_to", 14, 1'b0, 32'h9999_9999, 1'b0, 32'h400, 32'h0, 4'hF);
    resp_phase("lw_to");

    // LW with ack on the 15th request cycle succeeds
    push_exp("lw_ack15", 1'b0, 32'hCAFE_F00D);
    start_op("lw_ack15", LwOp, 32'h0000_0404, 32'h0);
    busy_phase("lw_ack15", 14, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h404, 32'h0, 4'hF);
    resp_phase("lw_ack15");

    // Reset in the middle of BUSY
    start_op("lw_rst", LwOp, 32'h0000_0300, 32'h0);
    @(negedge clk);
    check("lw_rst_req_busy", {31'b0, u_if.bus_req_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("lw_rst_req_drop", {31'b0, u_if.bus_req_o}, 32'd0);
    check("lw_rst_stall_drop", {31'b0, u_if.stall_o}, 32'd0);
    check("lw_rst_be_drop", {28'b0, u_if.bus_be_o}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    u_if.bus_ack_i   = 1'b1;
    u_if.bus_rdata_i = 32'h7777_7777;
    @(negedge clk);
    check("stray_ack_req", {31'b0, u_if.bus_req_o}, 32'd0);
    @(posedge clk);
    #1 u_if.bus_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Non-memory op never stalls
    u_if.mem_op_valid = 1'b1;
    u_if.mem_op       = AddOp;
    u_if.mem_addr     = 32'h0000_0100;
    @(negedge clk);
    check("add_stall", {31'b0, u_if.stall_o}, 32'd0);
    @(posedge clk);
    #1 u_if.mem_op_valid = 1'b0;
    @(negedge clk);
    check("add_req", {31'b0, u_if.bus_req_o}, 32'd0);
    check("add_stall_after", {31'b0, u_if.stall_o}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("pending_resp", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
